if_fetch_queue: RTL and testbench

- Fetch-side buffer sitting directly downstream of the program counter, between the PC and the IF/ID boundary.
- Each cycle it takes the current PC and its link value and issues a request to the synchronous instruction memory, which has 1-cycle read latency.
- It captures the returned instruction together with its PC and PC_save in a small FIFO and presents entries to decode with a valid/ready handshake.
- Provides a credit-based stall back to the PC and a flush that discards buffered and in-flight fetches on a redirect (branch or JALR).

---
 rtl/if_fetch_queue_pkg.sv | 14 +
 rtl/if_fetch_queue_if.sv | 28 ++
 rtl/if_fetch_queue_fetch_fifo_mem.sv | 23 ++
 rtl/if_fetch_queue.sv | 101 ++++++++++
 tb/tb_if_fetch_queue.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/if_fetch_queue_pkg.sv
// Shared constants and the packed fetch-entry layout for the instruction-fetch queue.
package if_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam int unsigned IF_DEPTH  = 2;
  localparam int unsigned IF_SIZE   = 32;

  typedef struct packed {
    logic [31:0]        instr;
    logic [IF_SIZE-1:0] pc;
    logic [IF_SIZE-1:0] pc_save;
  } fetch_entry_t;

endpackage

// File: rtl/if_fetch_queue_if.sv
// PC / instruction-memory / decode-side signal bundle of the fetch queue.
interface if_fetch_queue_if #(
  parameter int unsigned size = 32
);
  logic [size-1:0] pc_in;
  logic [size-1:0] pc_save_in;
  logic            fetch_en;
  logic            pc_stall;
  logic            imem_req;
  logic [size-1:0] imem_addr;
  logic [31:0]     imem_rdata;
  logic            flush;
  logic            id_ready;
  logic            id_valid;
  logic [31:0]     id_instr;
  logic [size-1:0] id_pc;
  logic [size-1:0] id_pc_save;

  modport slave (
    input  pc_in, pc_save_in, fetch_en, imem_rdata, flush, id_ready,
    output pc_stall, imem_req, imem_addr, id_valid, id_instr, id_pc, id_pc_save
  );

  modport master (
    output pc_in, pc_save_in, fetch_en, imem_rdata, flush, id_ready,
    input  pc_stall, imem_req, imem_addr, id_valid, id_instr, id_pc, id_pc_save
  );
endinterface

// File: rtl/if_fetch_queue_fetch_fifo_mem.sv
// Fetch-entry storage: DEPTH x W register array, pointer-indexed, no control logic.
module fetch_fifo_mem #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned W     = 96,
  parameter int unsigned ptr_w = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [ptr_w-1:0] waddr,
  input  logic [W-1:0]     wdata,
  input  logic [ptr_w-1:0] raddr,
  output logic [W-1:0]     rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/if_fetch_queue.sv
// Fetch buffer between PC and IF/ID: issues 1-cycle-latency imem reads, queues the
// returned words with their PC tags, and throttles the PC with a credit-based stall.
module if_fetch_queue
  import if_pkg::*;
#(
  parameter int unsigned size  = IF_SIZE,
  parameter int unsigned DEPTH = IF_DEPTH,
  parameter int unsigned ptr_w = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            reset,
  if_fetch_queue_if.slave bus
);

  localparam int unsigned CNT_W    = ptr_w + 1;
  localparam int unsigned CREDIT_W = CNT_W + 1;

  typedef struct packed {
    logic [31:0]     instr;
    logic [size-1:0] pc;
    logic [size-1:0] pc_save;
  } entry_t;

  logic [CNT_W-1:0]    count;
  logic [ptr_w-1:0]    wr_ptr;
  logic [ptr_w-1:0]    rd_ptr;
  logic                inflight;
  logic [size-1:0]     tag_pc;
  logic [size-1:0]     tag_pc_save;
  logic [CREDIT_W-1:0] credit_used;
  logic                stall;
  logic                req;
  logic                push;
  logic                pop;
  logic                valid;
  entry_t              wdata;
  entry_t              head;

  // A slot is reserved at request time, so in-flight reads count against capacity.
  assign credit_used = CREDIT_W'(count) + CREDIT_W'(inflight);
  assign stall       = credit_used >= CREDIT_W'(DEPTH);

  // Gated by reset so the strobe is low while the block is held in reset.
  assign req   = bus.fetch_en & ~stall & ~bus.flush & reset;
  assign push  = inflight & ~bus.flush;
  assign valid = (count != '0);
  assign pop   = valid & bus.id_ready & ~bus.flush;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count       <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      inflight    <= 1'b0;
      tag_pc      <= '0;
      tag_pc_save <= '0;
    end else if (bus.flush) begin
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      inflight <= 1'b0;
    end else begin
      inflight <= req;
      if (req) begin
        tag_pc      <= bus.pc_in;
        tag_pc_save <= bus.pc_save_in;
      end
      if (push) wr_ptr <= wr_ptr + ptr_w'(1);
      if (pop)  rd_ptr <= rd_ptr + ptr_w'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign wdata = '{instr: bus.imem_rdata, pc: tag_pc, pc_save: tag_pc_save};

  fetch_fifo_mem #(
    .DEPTH (DEPTH),
    .W     ($bits(entry_t)),
    .ptr_w (ptr_w)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (wdata),
    .raddr (rd_ptr),
    .rdata (head)
  );

  assign bus.pc_stall   = stall;
  assign bus.imem_req   = req;
  assign bus.imem_addr  = bus.pc_in;
  assign bus.id_valid   = valid;
  assign bus.id_instr   = valid ? head.instr   : NOP_INSTR;
  assign bus.id_pc      = valid ? head.pc      : '0;
  assign bus.id_pc_save = valid ? head.pc_save : '0;

endmodule

// File: tb/tb_if_fetch_queue.sv
// Scoreboard bench for if_fetch_queue: queue-based reference model, randomized and directed stimulus.
module tb_if_fetch_queue;
  import if_pkg::*;

  localparam int unsigned DEPTH = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  if_fetch_queue_if #(.size(32)) bus ();

  if_fetch_queue #(.size(32), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  fetch_entry_t exp_q[$];
  fetch_entry_t head;
  bit           mon_en = 1'b0;
  logic         exp_valid, exp_stall, exp_req;
  logic [31:0]  exp_addr;
  bit           m_inflight;
  logic [31:0]  m_tag_pc, m_tag_ps;
  bit           p_flush, p_req;
  logic [31:0]  p_pc, p_ps, p_rdata;
  int           req_seen;
  bit           dead_seen;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares outputs at the falling edge and retires entries decode accepts.
  always @(negedge clk) begin
    if (mon_en) begin
      check("id_valid", 64'(bus.id_valid), 64'(exp_valid));
      check("pc_stall", 64'(bus.pc_stall), 64'(exp_stall));
      check("imem_req", 64'(bus.imem_req), 64'(exp_req));
      if (exp_req) check("imem_addr", 64'(bus.imem_addr), 64'(exp_addr));
      if (exp_valid && exp_q.size() != 0) begin
        head = exp_q[0];
        check("id_instr", 64'(bus.id_instr), 64'(head.instr));
        check("id_pc", 64'(bus.id_pc), 64'(head.pc));
        check("id_pc_save", 64'(bus.id_pc_save), 64'(head.pc_save));
        if (bus.id_ready && !bus.flush) void'(exp_q.pop_front());
      end else if (!exp_valid) begin
        check("empty_instr", 64'(bus.id_instr), 64'(NOP_INSTR));
        check("empty_pc", 64'(bus.id_pc), 64'd0);
        check("empty_pc_save", 64'(bus.id_pc_save), 64'd0);
      end
      if (bus.imem_req) req_seen++;
      if (bus.id_valid && bus.id_instr == 32'h0000_DEAD) dead_seen = 1'b1;
    end
  end

  // One clock cycle of stimulus; the model first applies what the previous cycle did at the edge.
  task automatic drive_cycle(input bit fe, input bit rdy, input bit fl,
                             input logic [31:0] pc, input logic [31:0] ps,
                             input bit rd_from_pc, input logic [31:0] rd);
    fetch_entry_t e;
    @(posedge clk);
    if (p_flush) begin
      exp_q.delete();
    end else if (m_inflight) begin
      e.instr   = p_rdata;
      e.pc      = m_tag_pc;
      e.pc_save = m_tag_ps;
      exp_q.push_back(e);
    end
    if (p_req) begin
      m_tag_pc = p_pc;
      m_tag_ps = p_ps;
    end
    m_inflight = p_req;
    #1;
    if (rd_from_pc) rd = 32'hA0 + m_tag_pc;
    exp_stall = (exp_q.size() + int'(m_inflight)) >= int'(DEPTH);
    exp_valid = (exp_q.size() != 0);
    exp_req   = fe && !exp_stall && !fl;
    exp_addr  = pc;
    bus.fetch_en   = fe;
    bus.id_ready   = rdy;
    bus.flush      = fl;
    bus.pc_in      = pc;
    bus.pc_save_in = ps;
    bus.imem_rdata = rd;
    p_flush = fl;
    p_req   = exp_req;
    p_pc    = pc;
    p_ps    = ps;
    p_rdata = rd;
    mon_en  = 1'b1;
  endtask

  // Drops reset between clock edges and checks the immediate asynchronous effect.
  task automatic do_reset();
    mon_en = 1'b0;
    #2;
    reset          = 1'b0;
    bus.fetch_en   = 1'b1;
    bus.flush      = 1'b0;
    bus.id_ready   = 1'b0;
    bus.imem_rdata = 32'h0000_0BAD;
    #1;
    check("rst_id_valid", 64'(bus.id_valid), 64'd0);
    check("rst_id_instr", 64'(bus.id_instr), 64'(NOP_INSTR));
    check("rst_id_pc", 64'(bus.id_pc), 64'd0);
    check("rst_id_pc_save", 64'(bus.id_pc_save), 64'd0);
    check("rst_imem_req", 64'(bus.imem_req), 64'd0);
    exp_q.delete();
    m_inflight = 1'b0;
    p_flush    = 1'b0;
    p_req      = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    reset        = 1'b1;
    bus.fetch_en = 1'b0;
    #1;
    check("rst_release_stall", 64'(bus.pc_stall), 64'd0);
  endtask

  initial begin
    logic [31:0] pc;
    reset          = 1'b1;
    bus.fetch_en   = 1'b0;
    bus.id_ready   = 1'b0;
    bus.flush      = 1'b0;
    bus.pc_in      = '0;
    bus.pc_save_in = '0;
    bus.imem_rdata = '0;
    do_reset();

    // Basic fetch of pc 0,1,2; the PC holds while stalled.
    pc = 0;
    for (int i = 0; i < 20 && pc < 3; i++) begin
      drive_cycle(1'b1, 1'b1, 1'b0, pc, 32'h100 + pc, 1'b1, 32'h0);
      if (exp_req) pc++;
    end
    for (int i = 0; i < 4; i++) drive_cycle(1'b0, 1'b1, 1'b0, pc, 32'h0, 1'b1, 32'h0);

    // Backpressure: exactly DEPTH requests get through, then drain in order.
    req_seen = 0;
    pc = 32'h40;
    for (int i = 0; i < 6; i++) begin
      drive_cycle(1'b1, 1'b0, 1'b0, pc, ~pc, 1'b1, 32'h0);
      if (exp_req) pc++;
    end
    @(negedge clk);
    #1;
    check("bp_req_pulses", 64'(req_seen), 64'd2);
    for (int i = 0; i < 4; i++) drive_cycle(1'b0, 1'b1, 1'b0, pc, 32'h0, 1'b1, 32'h0);

    // Flush while a fetch is in flight: its response must be dropped.
    dead_seen = 1'b0;
    drive_cycle(1'b1, 1'b0, 1'b0, 32'd5, 32'd9, 1'b0, 32'h1234);
    drive_cycle(1'b1, 1'b0, 1'b1, 32'd6, 32'd9, 1'b0, 32'h0000_DEAD);
    for (int i = 0; i < 3; i++) drive_cycle(1'b0, 1'b1, 1'b0, 32'd7, 32'd0, 1'b0, $urandom);
    check("flush_dead_never_seen", 64'(dead_seen), 64'd0);

    // Sustained fetch with decode always ready: simultaneous push/pop, several pointer wraps.
    pc = 32'h200;
    for (int i = 0; i < 16; i++) begin
      drive_cycle(1'b1, 1'b1, 1'b0, pc, pc + 32'h8, 1'b0, $urandom);
      if (exp_req) pc++;
    end

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      drive_cycle(($urandom_range(3) != 0), ($urandom_range(9) < 6), ($urandom_range(11) == 0),
                  $urandom, $urandom, 1'b0, $urandom);
    end

    // Fill the queue, then reset asynchronously mid-stream.
    pc = 32'h300;
    for (int i = 0; i < 4; i++) begin
      drive_cycle(1'b1, 1'b0, 1'b0, pc, pc, 1'b1, 32'h0);
      if (exp_req) pc++;
    end
    do_reset();
    for (int i = 0; i < 6; i++) drive_cycle(1'b1, 1'b1, 1'b0, 32'h400 + i, 32'h0, 1'b1, 32'h0);
    @(negedge clk);
    #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
